// File: rtl/fifo_rd_unpacker_if.sv
// Bundle between a show-ahead FIFO read port, the unpacker, and its narrow beat consumer.
// The master modport is the unpacker side; the slave modport is the FIFO + consumer side.
interface fifo_rd_unpacker_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 fifo_empty_i;
  logic [IN_WIDTH-1:0]  fifo_data_i;
  logic                 fifo_rd_en_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [OUT_WIDTH-1:0] out_data_o;
  logic                 out_last_o;
  logic                 busy_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_data_i,
    output fifo_rd_en_o,
    output out_valid_o,
    input  out_ready_i,
    output out_data_o,
    output out_last_o,
    output busy_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_data_i,
    input  fifo_rd_en_o,
    input  out_valid_o,
    output out_ready_i,
    input  out_data_o,
    input  out_last_o,
    input  busy_o
  );
endinterface

// File: rtl/fifo_rd_unpacker.sv
// Pops IN_WIDTH-bit words from a show-ahead FIFO and streams them as IN_WIDTH/OUT_WIDTH
// valid/ready beats, LSB slice first. Define UNPACK_MSB_FIRST_EN to send the MSB slice first.
module fifo_rd_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_rd_unpacker_if.master    bus
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (RATIO < 1 || (IN_WIDTH % OUT_WIDTH) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_cfg
    $error("fifo_rd_unpacker: IN_WIDTH/OUT_WIDTH must be an integer power of two >= 1");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] word_q, word_d;
  logic                last_beat;
  logic [CNT_W-1:0]    slice_idx;
  logic [IN_WIDTH-1:0] shifted;

  assign last_beat = (cnt_q == CNT_W'(RATIO - 1));

`ifdef UNPACK_MSB_FIRST_EN
  assign slice_idx = CNT_W'(RATIO - 1) - cnt_q;
`else
  assign slice_idx = cnt_q;
`endif

  assign shifted = word_q >> (slice_idx * OUT_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // The last-beat handshake reloads straight from the FIFO head so words stream without a bubble.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    word_d           = word_q;
    bus.fifo_rd_en_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.fifo_empty_i) begin
          bus.fifo_rd_en_o = 1'b1;
          word_d           = bus.fifo_data_i;
          cnt_d            = '0;
          state_d          = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready_i) begin
          if (!last_beat) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!bus.fifo_empty_i) begin
            bus.fifo_rd_en_o = 1'b1;
            word_d           = bus.fifo_data_i;
            cnt_d            = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid_o = (state_q == SEND);
  assign bus.busy_o      = (state_q == SEND);
  assign bus.out_last_o  = (state_q == SEND) && last_beat;
  assign bus.out_data_o  = (state_q == SEND) ? shifted[OUT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Directed bench for fifo_rd_unpacker: a per-cycle vector table for the 32->8 instance and
// a hand-written sequence for the 8->8 (single-beat) instance.
module tb_fifo_rd_unpacker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_unpacker_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus();
  fifo_rd_unpacker_if #(.IN_WIDTH(8),  .OUT_WIDTH(8)) bus8();

  fifo_rd_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fifo_rd_unpacker #(.IN_WIDTH(8), .OUT_WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  typedef struct {
    logic        rst;
    logic        empty;
    logic [31:0] data;
    logic        ready;
    logic        chk;
    logic        rd_en;
    logic        valid;
    logic [7:0]  odata;
    logic        last;
    logic        busy;
  } vec_t;

  vec_t v[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] W1 = 32'hDDCCBBAA;
  localparam logic [31:0] WA = 32'h44332211;
  localparam logic [31:0] WB = 32'h88776655;
  localparam logic [31:0] W4 = 32'h00000011;

  // Expected beat k (0 = first sent) of a 32-bit word.
  function automatic logic [7:0] beat(input logic [31:0] w, input int k);
`ifdef UNPACK_MSB_FIRST_EN
    return w[(3 - k) * 8 +: 8];
`else
    return w[k * 8 +: 8];
`endif
  endfunction

  task automatic add(input logic r, input logic e, input logic [31:0] d, input logic rdy,
                     input logic c, input logic re, input logic vl, input logic [7:0] od,
                     input logic ls, input logic b);
    vec_t t;
    t = '{r, e, d, rdy, c, re, vl, od, ls, b};
    v.push_back(t);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  logic [6:0] rdy_pat;
  int         idx_seq [7] = '{0, 1, 1, 1, 2, 2, 3};

  initial begin
    rst = 1'b1;
    bus.fifo_empty_i  = 1'b1;
    bus.fifo_data_i   = '0;
    bus.out_ready_i   = 1'b0;
    bus8.fifo_empty_i = 1'b1;
    bus8.fifo_data_i  = '0;
    bus8.out_ready_i  = 1'b0;
    rdy_pat = 7'b1101001;

    // reset
    add(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
    // single word, ready held high
    add(0, 0, W1, 1, 1, 1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 1, 0, 1, 1, 0, 1, beat(W1, k), k == 3, 1);
    add(0, 1, 0, 1, 1, 0, 0, 8'h00, 0, 0);
    // two words back to back
    add(0, 0, WA, 1, 1, 1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, WB, 1, 1, k == 3, 1, beat(WA, k), k == 3, 1);
    for (int k = 0; k < 4; k++) add(0, 1, 0, 1, 1, 0, 1, beat(WB, k), k == 3, 1);
    add(0, 1, 0, 1, 1, 0, 0, 8'h00, 0, 0);
    // ready toggling; a transient non-empty mid-word must not pop
    add(0, 0, W1, 1, 1, 1, 0, 8'h00, 0, 0);
    for (int j = 0; j < 7; j++)
      add(0, (j == 4) ? 1'b0 : 1'b1, (j == 4) ? 32'h12345678 : 32'h0, rdy_pat[j], 1,
          0, 1, beat(W1, idx_seq[j]), idx_seq[j] == 3, 1);
    add(0, 1, 0, 1, 1, 0, 0, 8'h00, 0, 0);
    // reset after beat BB, then a fresh word
    add(0, 0, W1, 1, 1, 1, 0, 8'h00, 0, 0);
    add(0, 1, 0, 1, 1, 0, 1, beat(W1, 0), 0, 1);
    add(0, 1, 0, 1, 1, 0, 1, beat(W1, 1), 0, 1);
    add(1, 1, 0, 0, 1, 0, 1, beat(W1, 2), 0, 1);
    add(0, 0, W4, 1, 1, 1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 1, 0, 1, 1, 0, 1, beat(W4, k), k == 3, 1);
    add(0, 1, 0, 1, 1, 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      rst              = v[i].rst;
      bus.fifo_empty_i = v[i].empty;
      bus.fifo_data_i  = v[i].data;
      bus.out_ready_i  = v[i].ready;
      #1;
      if (v[i].chk) begin
        check("rd_en", i, 32'(bus.fifo_rd_en_o), 32'(v[i].rd_en));
        check("valid", i, 32'(bus.out_valid_o),  32'(v[i].valid));
        check("data",  i, 32'(bus.out_data_o),   32'(v[i].odata));
        check("last",  i, 32'(bus.out_last_o),   32'(v[i].last));
        check("busy",  i, 32'(bus.busy_o),       32'(v[i].busy));
      end
    end

    // single-beat instance: 0x5A then 0xA5 on consecutive cycles, then idle forever
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus8.fifo_empty_i = 1'b0; bus8.fifo_data_i = 8'h5A; bus8.out_ready_i = 1'b1;
    #1;
    check("r1_rd_en0", 100, 32'(bus8.fifo_rd_en_o), 32'd1);
    check("r1_valid0", 100, 32'(bus8.out_valid_o),  32'd0);
    @(negedge clk);
    bus8.fifo_data_i = 8'hA5;
    #1;
    check("r1_data1",  101, 32'(bus8.out_data_o),   32'h5A);
    check("r1_last1",  101, 32'(bus8.out_last_o),   32'd1);
    check("r1_rd_en1", 101, 32'(bus8.fifo_rd_en_o), 32'd1);
    @(negedge clk);
    bus8.fifo_empty_i = 1'b1; bus8.fifo_data_i = 8'h00;
    #1;
    check("r1_data2",  102, 32'(bus8.out_data_o),   32'hA5);
    check("r1_last2",  102, 32'(bus8.out_last_o),   32'd1);
    check("r1_rd_en2", 102, 32'(bus8.fifo_rd_en_o), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      check("r1_idle_valid", 103 + c, 32'(bus8.out_valid_o),  32'd0);
      check("r1_idle_rd_en", 103 + c, 32'(bus8.fifo_rd_en_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
